// File: rtl/cacheline_adapter.sv
// Bridges single 256-bit cache-line reads/writes from the cache arbiter onto
// four-beat 64-bit bursts on the banked main-memory port.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_REQ   = 3'd1;
  localparam logic [2:0] ST_RD_DATA  = 3'd2;
  localparam logic [2:0] ST_WR_BURST = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]   state_q,     state_d;
  logic [26:0]  line_addr_q, line_addr_d;
  logic [255:0] line_buf_q,  line_buf_d;
  logic [1:0]   cnt_q,       cnt_d;

  logic         last_beat;
  logic [7:0]   beat_lsb;
  logic         unused_addr_lsbs;

  // cnt parks at 3 after the final beat; only a new request clears it, so it
  // never wraps inside a burst.
  assign last_beat        = (cnt_q == 2'd3);
  assign beat_lsb         = {cnt_q, 6'd0};
  assign unused_addr_lsbs = ^dfp_addr[4:0];

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no branch
    // can leave one unassigned and infer a latch.
    state_d     = state_q;
    line_addr_d = line_addr_q;
    line_buf_d  = line_buf_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (dfp_read) begin
          line_addr_d = dfp_addr[31:5];
          cnt_d       = 2'd0;
          state_d     = ST_RD_REQ;
        end else if (dfp_write) begin
          line_addr_d = dfp_addr[31:5];
          line_buf_d  = dfp_wdata;
          cnt_d       = 2'd0;
          state_d     = ST_WR_BURST;
        end
      end

      ST_RD_REQ: begin
        if (bmem_ready) begin
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (bmem_rvalid) begin
          line_buf_d[beat_lsb +: 64] = bmem_rdata;
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_WR_BURST: begin
        if (bmem_ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  // NOTE: line_buf is a plain register bank (not a RAM) and its value is
  // visible on dfp_rdata, so it is reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      line_buf_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      line_buf_q  <= line_buf_d;
      cnt_q       <= cnt_d;
    end
  end

  // Every output is a function of registered state only.
  assign dfp_rdata  = line_buf_q;
  assign dfp_resp   = (state_q == ST_DONE);
  assign bmem_addr  = {line_addr_q, 5'd0};
  assign bmem_read  = (state_q == ST_RD_REQ);
  assign bmem_write = (state_q == ST_WR_BURST);
  assign bmem_wdata = bmem_write ? line_buf_q[beat_lsb +: 64] : 64'd0;

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Converts 256-bit cache-line requests into 64-bit, four-beat burst transactions on the banked main-memory port. It sits directly below the icache/dcache arbiter: it accepts one line read or write from the arbiter at a time, sequences the burst, assembles or serialises the line, and returns a single-cycle response.

## Interface
- No parameters. Line is fixed at 256 bits, beat at 64 bits, burst length at 4.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- dfp_addr  input  32  line address from the arbiter; bits [4:0] are ignored.
- dfp_read  input  1  line read request; held until dfp_resp.
- dfp_write  input  1  line write request; held until dfp_resp.
- dfp_wdata  input  256  write line; beat k is bits [64k+63:64k].
- dfp_rdata  output  256  read line, registered; valid while dfp_resp is high.
- dfp_resp  output  1  single-cycle completion pulse.
- bmem_addr  output  32  burst address, {line_addr[31:5], 5'b0}.
- bmem_read  output  1  burst read request.
- bmem_write  output  1  write beat valid.
- bmem_wdata  output  64  current write beat.
- bmem_ready  input  1  memory accepts a read request or write beat this cycle.
- bmem_rdata  input  64  read beat.
- bmem_rvalid  input  1  read beat valid.

## Operation
- The FSM has five states: IDLE, RD_REQ, RD_DATA, WR_BURST and DONE.
- Internal registers:
  - line_addr (27 bits, addr[31:5]).
  - line_buf (256 bits).
  - beat counter cnt (2 bits plus a last flag, or 3 bits).
- **IDLE**
  - On dfp_read: latch line_addr, cnt=0, go to RD_REQ.
  - Else on dfp_write: latch line_addr and line_buf=dfp_wdata, cnt=0, go to WR_BURST.
  - If both are high, read wins. This is illegal upstream, but the behaviour is defined.
- **RD_REQ**
  - Drive bmem_read=1 and bmem_addr.
  - When bmem_ready=1, go to RD_DATA. Otherwise hold.
- **RD_DATA**
  - bmem_read=0.
  - On each bmem_rvalid: line_buf[64*cnt +: 64] <= bmem_rdata, then cnt++.
  - Gaps between beats are allowed.
  - On the 4th beat (cnt==3 with rvalid), go to DONE.
- **WR_BURST**
  - Drive bmem_write=1, bmem_addr, and bmem_wdata=line_buf[64*cnt +: 64].
  - When bmem_ready=1, cnt++.
  - When the 4th beat is accepted, go to DONE.
  - bmem_addr stays at the line base for all four beats.
- **DONE**
  - dfp_resp=1 and dfp_rdata=line_buf for exactly one cycle, then go to IDLE.
  - After a write, dfp_rdata shows the written line; the arbiter ignores it.
- Request signals are sampled only in IDLE. Changes to dfp_* in other states are ignored, because addr and wdata are latched.
- bmem_rvalid outside RD_DATA is ignored.
- dfp_rdata holds its value between transactions. It changes only in RD_DATA and on a write latch.

## Timing
- **Reset:** asynchronous assertion forces IDLE immediately, including mid-burst. The reset value of every output is 0:
  - dfp_resp, dfp_rdata
  - bmem_read, bmem_write, bmem_addr, bmem_wdata
  - line_buf, cnt
- A burst aborted by reset is not resumed.
- **Read latency:**
  - Request seen in IDLE at cycle 0.
  - bmem_read is high from cycle 1.
  - Best case, bmem_ready is high in cycle 1 and beats arrive on cycles 2–5. Then dfp_resp is high in cycle 6.
- **Write latency:**
  - bmem_write is high from cycle 1.
  - Best case, with ready always high, beats are accepted on cycles 1–4 and dfp_resp is high in cycle 5.
- **Back-to-back:**
  - The arbiter must drop its request on or before the cycle after dfp_resp.
  - A request still high in the IDLE cycle after DONE starts a new transaction. One idle cycle minimum separates transactions.
- All bmem_* outputs are driven from state and registers only, with no combinational path from dfp_* inputs.
- **Boundary cases:**
  - bmem_ready low throughout: RD_REQ or WR_BURST holds indefinitely with outputs stable.
  - cnt wraps only via return to IDLE. It never wraps within a burst.

## Test plan
- **Read, no stalls.**
  - Stimulus: dfp_read, addr 0x1234_5678; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive rvalids.
  - Required: bmem_addr=0x1234_5660; dfp_resp one cycle at cycle 6; dfp_rdata={0x44..,0x33..,0x22..,0x11..}.
- **Read with gaps.**
  - Stimulus: bmem_ready low 3 cycles in RD_REQ; rvalid gaps of 2 cycles between beats.
  - Required: bmem_read held stable; same assembled line; exactly one dfp_resp.
- **Write with backpressure.**
  - Stimulus: dfp_write, addr 0x8000_0040, wdata beats 0xA0..A3; ready toggling 1,0,1,1,0,1.
  - Required: bmem_wdata shows A0, A1, A2, A3 in order, each held until accepted; bmem_addr=0x8000_0040; dfp_resp after the 4th accepted beat.
- **Simultaneous read and write in IDLE.**
  - Required: the read burst executes; no bmem_write pulse.
- **Async reset mid-write.**
  - Stimulus: assert rst after 2 beats.
  - Required: all outputs 0 in the same cycle without waiting for a clock edge; a following read of 0x100 completes normally with correct data.
- **Spurious rvalid.**
  - Stimulus: rvalid pulses with data 0xDEAD in IDLE and WR_BURST.
  - Required: dfp_rdata unchanged; no dfp_resp.
